// File: rtl/div_iter32.sv
// div_iter32: iterative radix-2 restoring divider, one quotient bit per cycle.
// Signed/unsigned operands, valid/ready on both sides, synchronous flush.
// Optional feature macro: DIV_EARLY_OUT_EN (skip CALC when divisor==0 or
// |dividend| < |divisor|; results are bit-identical to the full path).
//
// Handshake: an operation is accepted on a rising edge where
// in_valid & in_ready & !flush; a result is consumed on a rising edge where
// out_valid & out_ready & !flush. in_ready/out_valid depend only on state.
module div_iter32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH:0]   prem_q, prem_d;   // partial remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;     // |divisor|
  logic [WIDTH-1:0] raw_q, raw_d;     // raw dividend for the divide-by-zero result
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_out_q, dbz_out_d;

  logic             dvd_neg, dvs_neg, accept;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   r_shift, r_sub;

  assign dvd_neg  = is_signed & dividend[WIDTH-1];
  assign dvs_neg  = is_signed & divisor[WIDTH-1];
  // |-2^(W-1)| wraps to 2^(W-1), which is correct as an unsigned magnitude
  assign dvd_abs  = dvd_neg ? (WIDTH'(0) - dividend) : dividend;
  assign dvs_abs  = dvs_neg ? (WIDTH'(0) - divisor) : divisor;
  assign accept   = in_valid & (state_q == S_IDLE) & ~flush;
  assign r_shift  = {prem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign r_sub    = r_shift - {1'b0, dvs_q};

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_out_q;
  assign dbg_state   = state_q;

  // Next-state and datapath update for each FSM state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    prem_d    = prem_q;
    dvs_d     = dvs_q;
    raw_d     = raw_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    dbz_d     = dbz_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_out_d = dbz_out_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = dvd_abs;
          prem_d  = '0;
          dvs_d   = dvs_abs;
          raw_d   = dividend;
          qsign_d = dvd_neg ^ dvs_neg;
          rsign_d = dvd_neg;
          dbz_d   = (divisor == '0);
          cnt_d   = '0;
          state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
          if ((divisor == '0) || (dvd_abs < dvs_abs)) begin
            acc_d   = '0;                 // quotient is zero
            prem_d  = {1'b0, dvd_abs};    // remainder is the whole magnitude
            state_d = S_FIX;
          end
`endif
        end
      end
      S_CALC: begin
        if (!r_sub[WIDTH]) begin
          prem_d = r_sub;
          acc_d  = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = r_shift;
          acc_d  = {acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (dbz_q) begin
          quo_d = '1;
          rem_d = raw_q;
        end else begin
          quo_d = qsign_q ? (WIDTH'(0) - acc_q) : acc_q;
          rem_d = rsign_q ? (WIDTH'(0) - prem_q[WIDTH-1:0]) : prem_q[WIDTH-1:0];
        end
        dbz_out_d = dbz_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      prem_q    <= '0;
      dvs_q     <= '0;
      raw_q     <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      dbz_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      prem_q    <= prem_d;
      dvs_q     <= dvs_d;
      raw_q     <= raw_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      dbz_q     <= dbz_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_out_q <= dbz_out_d;
    end
  end

endmodule

// File: tb/tb_div_iter32.sv
// tb_div_iter32: self-checking bench for div_iter32 (WIDTH=32).
module tb_div_iter32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int fails = 0;

  div_iter32 #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on wide integers
  function automatic void ref_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                  input logic sg, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output logic z);
    longint a, b;
    if (dv == '0) begin
      q = '1; r = dd; z = 1'b1;
    end else begin
      if (sg) begin
        a = longint'($signed(dd));
        b = longint'($signed(dv));
      end else begin
        a = longint'({32'd0, dd});
        b = longint'({32'd0, dv});
      end
      q = W'(a / b);
      r = W'(a % b);
      z = 1'b0;
    end
  endfunction

  // Expected edges from accept to out_valid (accept edge counted as 1)
  function automatic int exp_lat(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sg);
    longint a, b;
    a = (sg && dd[W-1]) ? -longint'($signed(dd)) : longint'({32'd0, dd});
    b = (sg && dv[W-1]) ? -longint'($signed(dv)) : longint'({32'd0, dv});
`ifdef DIV_EARLY_OUT_EN
    if (dv == '0 || a < b) return 2;
`endif
    return W + 2;
  endfunction

  // Driver: present operands, wait for accept, then count edges to out_valid.
  // Leaves the DUT in DONE (out_ready low) when it returns with lat > 0.
  task automatic start_and_wait(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                input logic sg, output int lat);
    int n;
    dividend = dd; divisor = dv; is_signed = sg; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    dividend  = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = 0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] dd,
                          input logic [W-1:0] dv, input logic sg, input bit chk_lat);
    logic [W-1:0] eq, er;
    logic ez;
    int lat;
    ref_div(dd, dv, sg, eq, er, ez);
    start_and_wait(dd, dv, sg, lat);
    tests_run++;
    if (lat == 0) begin
      fails++;
      $display("FAIL %s timeout: out_valid never rose", name);
    end else begin
      if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        fails++;
        $display("FAIL %s dd=%h dv=%h s=%0d: got q=%h r=%h z=%0d, want q=%h r=%h z=%0d",
                 name, dd, dv, sg, quotient, remainder, div_by_zero, eq, er, ez);
      end
      if (chk_lat) begin
        tests_run++;
        if (lat != exp_lat(dd, dv, sg)) begin
          fails++;
          $display("FAIL %s latency: got %0d, want %0d", name, lat, exp_lat(dd, dv, sg));
        end
      end
      consume();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 ||
        remainder !== '0 || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b q=%h r=%h z=%b, want 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    check_op("s100_7", 32'd100, 32'd7, 1'b1, 1'b1);
    check_op("sneg100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1);
    check_op("u_max_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    check_op("s_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check_op("s_div0", 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
    check_op("u_div0", 32'h0000_1234, 32'd0, 1'b0, 1'b1);
    check_op("s_7_neg2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
    check_op("u_small_big", 32'd5, 32'hFFFF_FFF0, 1'b0, 1'b1);
  endtask

  task automatic test_hold();
    logic [W-1:0] eq, er;
    logic ez;
    int lat;
    bit bad;
    ref_div(32'd1000, 32'd33, 1'b0, eq, er, ez);
    start_and_wait(32'd1000, 32'd33, 1'b0, lat);
    bad = (lat == 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== eq ||
          remainder !== er || div_by_zero !== ez) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      fails++;
      $display("FAIL hold_stable: out_valid=%b in_ready=%b q=%h r=%h, want 1 0 %h %h",
               out_valid, in_ready, quotient, remainder, eq, er);
    end
    consume();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    check_op("after_hold", 32'd77, 32'd5, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    int seen;
    // Flush in CALC at iteration 10
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_calc: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      fails++;
      $display("FAIL flush_no_result: out_valid cycles=%0d, want 0", seen);
    end
    // Flush together with in_valid: nothing accepted
    dividend = 32'd9; divisor = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_with_valid: in_ready=%b, want 1", in_ready);
    end
    check_op("early_3_10", 32'd3, 32'd10, 1'b0, 1'b1);
    // Flush in DONE with out_ready: result dropped
    start_and_wait(32'd50, 32'd3, 1'b0, seen);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || seen == 0) begin
      fails++;
      $display("FAIL flush_done: out_valid=%b in_ready=%b lat=%0d, want 0 1 nonzero",
               out_valid, in_ready, seen);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    dividend = 32'd12345; divisor = 32'd11; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_op: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_no_result: out_valid cycles=%0d, want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] dd, dv, eq, er;
    logic sg, ez;
    int lat, bad;
    bad = 0;
    for (int i = 0; i < 1200; i++) begin
      sg = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: dd = 32'h8000_0000;
        1: dd = $urandom_range(0, 100);
        default: dd = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: dv = 32'hFFFF_FFFF;
        1: dv = $urandom_range(1, 16);
        2: dv = $urandom >> $urandom_range(0, 31);
        default: dv = $urandom;
      endcase
      if (dv == '0) dv = 32'd3;
      ref_div(dd, dv, sg, eq, er, ez);
      start_and_wait(dd, dv, sg, lat);
      tests_run++;
      if (lat != exp_lat(dd, dv, sg) || quotient !== eq || remainder !== er ||
          div_by_zero !== ez) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL random dd=%h dv=%h s=%0d: got q=%h r=%h z=%0d lat=%0d, want q=%h r=%h z=%0d lat=%0d",
                   dd, dv, sg, quotient, remainder, div_by_zero, lat, eq, er, ez,
                   exp_lat(dd, dv, sg));
      end
      if (lat == 0) continue;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
